// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - Pipeline hazard/stall controller with memory wait FSM (optional counters: HAZARD_PERF_CNT_EN)
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  // Last WaitCnt value before the N-th consecutive not-ready edge
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_err_q;
  logic       lw_stall;
  logic       mem_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // EX operand forwarding: M stage beats W stage, x0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      fwd_a = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) fwd_a = 2'b01;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      fwd_b = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) fwd_b = 2'b01;
  end

  // Hazard detection; a taken branch kills the dependent D instruction anyway
  always_comb begin
    lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    mem_stall = (MemReqM && !MemReadyM) || (state == MEM_ERR);
  end

  // Pipeline controls; memory stall freezes everything, reset forces all low
  always_comb begin
    ForwardAE = rst_n ? fwd_a : 2'b00;
    ForwardBE = rst_n ? fwd_b : 2'b00;
    StallF    = rst_n && (mem_stall || lw_stall);
    StallD    = rst_n && (mem_stall || lw_stall);
    StallE    = rst_n && mem_stall;
    StallM    = rst_n && mem_stall;
    FlushW    = rst_n && mem_stall;
    FlushD    = rst_n && PCSrcE && !mem_stall;
    FlushE    = rst_n && (PCSrcE || lw_stall) && !mem_stall;
    MemErr    = rst_n && mem_err_q;
  end

  // Memory access sequencing: wait, release on ready, sticky timeout error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM || !MemReqM) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= MEM_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        MEM_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating performance counters of stalled cycles and E-stage flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (FlushE && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign StallCycles = stall_cnt;
  assign FlushEvents = flush_cnt;
`else
  assign StallCycles = '0;
  assign FlushEvents = '0;
`endif

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall controller for the five-stage RISC-V core. It resolves EX-stage operand forwarding and load-use stalls, and flushes on taken branches and jumps. It also sequences multi-cycle data-memory accesses with a wait/timeout state machine. It sits beside the decode control unit and drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before a sticky error; legal range 2..255.
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in E.
- RdM, RdW  in  5 each  destinations in M and W.
- RegWriteM, RegWriteW  in  1 each  register-write enables in M and W.
- ResultSrcE  in  2  result select in E; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  load/store active in M.
- MemReadyM  in  1  data memory completes the M access this cycle.
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = W result, 10 = M ALU result.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register.
- MemErr  out  1  sticky memory-timeout error.
- StallCycles, FlushEvents  out  CNT_W each  performance counters.

## Operation
- Forwarding (combinational), per operand X in {1,2}:
  - Output 10 if RegWriteM && RdM!=0 && RdM==RsXE.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==RsXE.
  - Otherwise 00. M has priority over W.
- lwStall = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
- memStall = (MemReqM && !MemReadyM) || state==MEM_ERR.
- Output equations:
  - StallF = StallD = memStall || lwStall.
  - StallE = StallM = FlushW = memStall.
  - FlushD = PCSrcE && !memStall.
  - FlushE = (PCSrcE || lwStall) && !memStall.
- memStall has absolute priority. A branch in E is held with E and takes effect on the release cycle.
- State machine with states RUN, MEM_WAIT, MEM_ERR and an 8-bit wait counter WaitCnt:
  - RUN: if MemReqM && !MemReadyM, go to MEM_WAIT with WaitCnt=1. Otherwise stay.
  - MEM_WAIT, MemReadyM=1: go to RUN, WaitCnt=0.
  - MEM_WAIT, MemReqM=0: this is a protocol violation. Go to RUN, WaitCnt=0.
  - MEM_WAIT, WaitCnt==MEM_TIMEOUT-1 and still not ready: go to MEM_ERR.
  - MEM_WAIT, any other not-ready cycle: increment WaitCnt.
  - MEM_ERR: absorbing. MemErr=1, all four stalls and FlushW held at 1. Exit only via rst_n.
- MEM_TIMEOUT=N means the error is entered at the edge that ends the N-th consecutive not-ready cycle. MemReadyM on the N-th cycle completes the access normally.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state, with no added latency.
- A stalled access is released in the same cycle MemReadyM=1: memStall=0 in that cycle, and the pipeline advances at its closing edge.
- Back-to-back accesses: ready in cycle k, next MemReqM && !MemReadyM in cycle k+1 gives a new WAIT and a fresh WaitCnt=1.
- Reset (asynchronous): state=RUN, WaitCnt=0, MemErr=0, counters=0.
- While rst_n=0 every output is forced to 0 regardless of inputs.
- Reset asserted mid-wait or in MEM_ERR aborts to RUN immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCycles increments on every clock where StallF=1.
  - FlushEvents increments on every clock where FlushE=1.
  - Both saturate at all-ones and clear only on reset.
- HAZARD_PERF_CNT_EN undefined: counter registers are not built, and both ports are tied to 0.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. With RegWriteM=0 -> ForwardAE=01.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. Same case with RdE=0 -> all 0.
- Branch: PCSrcE=1, no memory activity -> FlushD=FlushE=1, StallF=0. With lwStall conditions also present, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> stalls and FlushW high for exactly 3 cycles, back in RUN, MemErr=0. Add PCSrcE=1 throughout -> FlushD/FlushE only on the ready cycle.
- Timeout, MEM_TIMEOUT=4: ready never asserted -> MemErr=1 after the 4th not-ready edge, stalls stick after MemReadyM later rises. Pulse rst_n low mid-cycle -> all outputs 0 immediately, state RUN.
- Counters, with HAZARD_PERF_CNT_EN: the load-use and 3-cycle wait sequences above -> StallCycles=4, FlushEvents=1. CNT_W=4 with 20 stall cycles -> StallCycles=15.
